// File: rtl/counter_datacheck.sv
// rtl/counter_datacheck.sv - receive-side checker for the incrementing counter stream; finds and locks the bit rotation, then counts errors.
// Optional first-error capture ports enabled by defining COUNTER_DATACHECK_FIRST_ERR_EN.
module counter_datacheck #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic [7:0]       data_out,
  output logic             data_out_valid,
  output logic [2:0]       rot_sel,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
`ifdef COUNTER_DATACHECK_FIRST_ERR_EN
  ,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_got,
  output logic             first_err_vld
`endif
);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // The match that lands on LOCK_LAST is the (LOCK_COUNT-1)th +1 step after the priming word.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 2);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  state_t           state_q;
  logic [2:0]       rot_q;
  logic             primed_q;
  logic [7:0]       prev_q;
  logic [7:0]       match_cnt_q;
  logic [7:0]       miss_cnt_q;
  logic [7:0]       expected_q;
  logic [7:0]       dout_q;
  logic             dout_valid_q;
  logic             lock_lost_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] word_q;

`ifdef COUNTER_DATACHECK_FIRST_ERR_EN
  logic [7:0]       fe_exp_q;
  logic [7:0]       fe_got_q;
  logic             fe_vld_q;
`endif

  logic [7:0]       rotated;
  logic [7:0]       prev_inc;
  logic             seq_match;
  logic             exp_match;
  logic [CNT_W-1:0] err_d;
  logic [CNT_W-1:0] word_d;

  // rotated[i] = data_in[(i + rot_q) mod 8]
  always_comb begin
    rotated = data_in;
    case (rot_q)
      3'd0: rotated = data_in;
      3'd1: rotated = {data_in[0],   data_in[7:1]};
      3'd2: rotated = {data_in[1:0], data_in[7:2]};
      3'd3: rotated = {data_in[2:0], data_in[7:3]};
      3'd4: rotated = {data_in[3:0], data_in[7:4]};
      3'd5: rotated = {data_in[4:0], data_in[7:5]};
      3'd6: rotated = {data_in[5:0], data_in[7:6]};
      3'd7: rotated = {data_in[6:0], data_in[7]};
      default: rotated = data_in;
    endcase
  end

  assign prev_inc  = prev_q + 8'd1;
  assign seq_match = (rotated == prev_inc);
  assign exp_match = (rotated == expected_q);
  assign err_d     = (err_q  == {CNT_W{1'b1}}) ? err_q  : err_q  + CNT_W'(1);
  assign word_d    = (word_q == {CNT_W{1'b1}}) ? word_q : word_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SEARCH;
      rot_q        <= 3'd0;
      primed_q     <= 1'b0;
      prev_q       <= 8'd0;
      match_cnt_q  <= 8'd0;
      miss_cnt_q   <= 8'd0;
      expected_q   <= 8'd0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      err_q        <= '0;
      word_q       <= '0;
`ifdef COUNTER_DATACHECK_FIRST_ERR_EN
      fe_exp_q     <= 8'd0;
      fe_got_q     <= 8'd0;
      fe_vld_q     <= 1'b0;
`endif
    end else begin
      lock_lost_q  <= 1'b0;
      dout_valid_q <= data_valid;
      if (data_valid) begin
        dout_q <= rotated;
        case (state_q)
          S_SEARCH: begin
            if (!primed_q) begin
              prev_q   <= rotated;
              primed_q <= 1'b1;
            end else if (seq_match) begin
              prev_q      <= rotated;
              match_cnt_q <= match_cnt_q + 8'd1;
              if (match_cnt_q == LOCK_LAST) begin
                state_q    <= S_LOCKED;
                expected_q <= rotated + 8'd1;
                miss_cnt_q <= 8'd0;
              end
            end else begin
              rot_q       <= rot_q + 3'd1;
              match_cnt_q <= 8'd0;
              primed_q    <= 1'b0;
            end
          end
          S_LOCKED: begin
            word_q     <= word_d;
            // Expected free-runs so a single corrupted word costs exactly one error.
            expected_q <= expected_q + 8'd1;
            if (exp_match) begin
              miss_cnt_q <= 8'd0;
            end else begin
              err_q      <= err_d;
              miss_cnt_q <= miss_cnt_q + 8'd1;
`ifdef COUNTER_DATACHECK_FIRST_ERR_EN
              if (!fe_vld_q) begin
                fe_exp_q <= expected_q;
                fe_got_q <= rotated;
                fe_vld_q <= 1'b1;
              end
`endif
              if (miss_cnt_q == LOSS_LAST) begin
                state_q     <= S_SEARCH;
                primed_q    <= 1'b0;
                match_cnt_q <= 8'd0;
                lock_lost_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_SEARCH;
        endcase
      end
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dout_valid_q;
  assign rot_sel        = rot_q;
  assign locked         = (state_q == S_LOCKED);
  assign lock_lost      = lock_lost_q;
  assign err_count      = err_q;
  assign word_count     = word_q;

`ifdef COUNTER_DATACHECK_FIRST_ERR_EN
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
  assign first_err_vld  = fe_vld_q;
`endif

endmodule
